prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter PREFILL, default 4, instruction words buffered before serial output starts.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, instruction word buffer depth (PREFILL <= FIFO_DEPTH).
REQ-003 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-004 SHALL have ports: in_valid in 1 word offered; in_ready out 1 word accepted when both high; in_data in 13 instruction word, bit 0 = ctrl bit; in_last in 1 final word of program.
REQ-005 SHALL have ports: load_en out 1 processor load enable; load_bit out 1 serial instruction bit (drives processor inReg[0]).
REQ-006 SHALL have ports: busy out 1 program in progress; done out 1 one-cycle completion pulse; err out 1 sticky underflow/overlength flag; instr_count out 10 words shifted in current/last program.

Function
REQ-007 SHALL implement states IDLE, FILL, SHIFT, DONE, ERR.
REQ-008 SHALL accept words (in_valid && in_ready) into a FIFO; in_ready = !full && !last_seen && state not in {DONE, ERR}; in ERR in_ready = 1 (drain).
REQ-009 IDLE -> FILL on first accepted word; that acceptance SHALL clear err and instr_count.
REQ-010 FILL -> SHIFT when FIFO count >= PREFILL or last_seen; load_en SHALL rise on the following clock edge.
REQ-011 In SHIFT, load_en = 1 every cycle with no gaps; load_bit = head word bit bit_idx, bit_idx 0..12 (LSB first), 13 cycles per word.
REQ-012 At bit_idx 12 the head word SHALL pop, instr_count increments, bit_idx wraps to 0; next word's bit 0 appears the next cycle.
REQ-013 Simultaneous push and pop in the same cycle SHALL both succeed, including at full.
REQ-014 At a pop leaving FIFO empty: if the popped word was the in_last word -> DONE; else -> ERR (underflow).
REQ-015 DONE: load_en = 0, done = 1 for exactly one cycle, then IDLE; guarantees >=1 cycle load_en low between programs (processor load counters restart on load_en rising edge).
REQ-016 ERR: load_en = 0, err = 1, FIFO flushed, input drained; on accepting a word with in_last -> IDLE; err stays 1 until next program's first accepted word.
REQ-017 busy = 1 in FILL, SHIFT, DONE, ERR.
REQ-018 load_bit SHALL be 0 whenever load_en = 0.
REQ-019 All outputs SHALL be registered except in_ready.

Reset
REQ-020 reset SHALL take priority over all activity, including mid-SHIFT: state IDLE, FIFO empty, last_seen 0, bit_idx 0.
REQ-021 Reset values: load_en 0, load_bit 0, busy 0, done 0, err 0, instr_count 0; in_ready 1 the cycle after reset deasserts.

Configuration
REQ-022 Macro PROG_LOADER_MAXLEN_EN defined: a word accepted when instr_count + FIFO count = 1000 SHALL be discarded, state -> ERR (err = 1, load_en low next cycle).
REQ-023 Macro PROG_LOADER_MAXLEN_EN undefined: no length check; instr_count wraps 1023 -> 0.

Structure
REQ-024 Package one_bit_pkg SHALL hold INSTR_W = 13, PC_W = 10, IMEM_DEPTH = 1000 and the loader state enum type.
REQ-025 FIFO SHALL be sub-module prog_loader_fifo (parameterised width/depth, push/pop/flush, count, full, empty).
REQ-026 prog_loader SHALL contain only FSM, bit_idx counter, serialiser and status logic.

Verification
REQ-027 3 words {0x0001, 0x1FFF, 0x0AAA}, last on third, in_valid continuous -> load_en high 39 consecutive cycles, bit streams LSB-first match, done pulses once, instr_count = 3, err = 0.
REQ-028 PREFILL = 4, send 2 words without last, stall -> load_en stays 0; send 2 more -> load_en rises next edge.
REQ-029 5 words started, source stalls 30 cycles after word 4 -> ERR at word 4 pop, err = 1, load_en low; remaining words with last drained; new program clears err.
REQ-030 reset asserted at bit 6 of word 2 -> next cycle load_en 0, busy 0, instr_count 0; following 1-word program completes normally.
REQ-031 Back-to-back programs (in_last then immediate in_valid) -> load_en low >=1 cycle between, second done pulse, instr_count reflects second program only.
REQ-032 With PROG_LOADER_MAXLEN_EN, 1001-word stream -> word 1001 discarded, err = 1; without macro, 1001 words shift, instr_count = 1001 mod 1024.

Source files
------------

// File: rtl/one_bit_pkg.sv
// Shared constants and loader state type for the one-bit processor program loader.
package one_bit_pkg;

  localparam int unsigned INSTR_W    = 13;
  localparam int unsigned PC_W       = 10;
  localparam int unsigned IMEM_DEPTH = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StShift,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/prog_loader_fifo.sv
// Instruction word FIFO with flush, occupancy count and a peek at the word after the head.
module prog_loader_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic [WIDTH-1:0]           head_next,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_incr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign do_push = push && (!full || do_pop);

  assign head      = mem[rd_ptr_q];
  assign head_next = (count_q >= CNT_W'(2)) ? mem[ptr_incr(rd_ptr_q)] : wdata;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_incr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_incr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Buffers instruction words and shifts them LSB-first into the processor via load_en/load_bit.
// Optional length check enabled by defining PROG_LOADER_MAXLEN_EN.
module prog_loader
  import one_bit_pkg::*;
#(
  parameter int unsigned PREFILL    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               load_en,
  output logic               load_bit,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PC_W-1:0]    instr_count
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(INSTR_W);

  loader_state_e    state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d, bit_idx_inc;
  logic             last_seen_q, last_seen_d;
  logic [PC_W-1:0]  instr_count_q, instr_count_d;
  logic             load_en_q, load_en_d, load_bit_q, load_bit_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic               accept, word_end, overlength;
  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_head, fifo_head_next;
  logic [CNT_W-1:0]   fifo_count;

  prog_loader_fifo #(
    .WIDTH(INSTR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .wdata    (in_data),
    .head     (fifo_head),
    .head_next(fifo_head_next),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign word_end    = (state_q == StShift) && (bit_idx_q == IDX_W'(INSTR_W - 1));
  assign bit_idx_inc = bit_idx_q + IDX_W'(1);
  assign accept      = in_valid && in_ready;
  assign fifo_pop    = word_end;
  assign fifo_flush  = (state_q == StErr);
  assign fifo_push   = accept && !overlength && (state_q inside {StIdle, StFill, StShift});

`ifdef PROG_LOADER_MAXLEN_EN
  logic [PC_W:0] words_held;
  assign words_held = {1'b0, instr_count_q} + (PC_W + 1)'(fifo_count);
  assign overlength = accept && (state_q inside {StFill, StShift}) &&
                      (words_held == (PC_W + 1)'(IMEM_DEPTH));
`else
  assign overlength = 1'b0;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StErr:   in_ready = 1'b1;
      StDone:  in_ready = 1'b0;
      default: in_ready = (!fifo_full || word_end) && !last_seen_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    last_seen_d   = last_seen_q;
    instr_count_d = instr_count_q;
    err_d         = err_q;
    load_en_d     = 1'b0;
    load_bit_d    = 1'b0;
    done_d        = 1'b0;

    if (accept && in_last && (state_q inside {StIdle, StFill, StShift})) last_seen_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d       = StFill;
          err_d         = 1'b0;
          instr_count_d = '0;
          bit_idx_d     = '0;
        end
      end
      StFill: begin
        if (overlength) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else if (!fifo_empty && ((fifo_count >= CNT_W'(PREFILL)) || last_seen_q)) begin
          state_d    = StShift;
          load_en_d  = 1'b1;
          load_bit_d = fifo_head[0];
          bit_idx_d  = '0;
        end
      end
      StShift: begin
        load_en_d = 1'b1;
        if (word_end) begin
          instr_count_d = instr_count_q + PC_W'(1);
          bit_idx_d     = '0;
          if ((fifo_count == CNT_W'(1)) && !fifo_push) begin
            // Nothing left to shift: a clean end only if the final word was flagged last.
            state_d   = last_seen_q ? StDone : StErr;
            done_d    = last_seen_q;
            err_d     = !last_seen_q;
            load_en_d = 1'b0;
          end else begin
            load_bit_d = fifo_head_next[0];
          end
        end else begin
          bit_idx_d  = bit_idx_inc;
          load_bit_d = fifo_head[bit_idx_inc];
        end
        if (overlength) begin
          state_d    = StErr;
          err_d      = 1'b1;
          done_d     = 1'b0;
          load_en_d  = 1'b0;
          load_bit_d = 1'b0;
          bit_idx_d  = '0;
        end
      end
      StDone: begin
        state_d     = StIdle;
        last_seen_d = 1'b0;
      end
      StErr: begin
        err_d       = 1'b1;
        last_seen_d = 1'b0;
        if (last_seen_q || (accept && in_last)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_idx_q     <= '0;
      last_seen_q   <= 1'b0;
      instr_count_q <= '0;
      load_en_q     <= 1'b0;
      load_bit_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      last_seen_q   <= last_seen_d;
      instr_count_q <= instr_count_d;
      load_en_q     <= load_en_d;
      load_bit_q    <= load_bit_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign load_en     = load_en_q;
  assign load_bit    = load_bit_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: program table plus hand-written corner sequences, bit scoreboard.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        load_en, load_bit, busy, done, err;
  logic [9:0]  instr_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit bitq[$];
  int run_len = 0, last_run = 0, run_cnt = 0, done_cnt = 0;

  typedef struct {
    int unsigned     n;
    logic [3:0][12:0] w;
    int unsigned     gap;
    int unsigned     exp_count;
    int unsigned     exp_run;
  } vec_t;
  vec_t vecs[4];

  prog_loader #(
    .PREFILL   (4),
    .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .load_en    (load_en),
    .load_bit   (load_bit),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Serial bit monitor: every load_en cycle consumes one expected bit.
  always @(negedge clk) begin
    bit exp_b;
    if (!reset) begin
      if (load_en) begin
        run_len++;
        if (bitq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bit_underrun: got load_en=1 expected no bits pending at %0t", $time);
        end else begin
          exp_b = bitq.pop_front();
          check("load_bit", 32'(load_bit), 32'(exp_b));
        end
      end else begin
        check("load_bit_idle", 32'(load_bit), 32'd0);
        if (run_len > 0) begin
          last_run = run_len;
          run_cnt++;
          run_len = 0;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic send_word(input logic [12:0] d, input logic l, input bit sb);
    bit acc;
    int t;
    acc = 1'b0;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc && t < 300) begin
      #1;
      acc = in_ready;
      step();
      t++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready expected accept of word %0h", d);
    end else if (sb) begin
      for (int i = 0; i < 13; i++) bitq.push_back(d[i]);
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int t;
    t = 0;
    while (done_cnt < target && t < 3000) begin
      step();
      t++;
    end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  initial begin
    int d0, r0, t, hi;

    vecs[0] = '{n: 3, w: {13'h0000, 13'h0AAA, 13'h1FFF, 13'h0001}, gap: 0, exp_count: 3,
                exp_run: 39};
    vecs[1] = '{n: 1, w: {13'h0000, 13'h0000, 13'h0000, 13'h1555}, gap: 0, exp_count: 1,
                exp_run: 13};
    vecs[2] = '{n: 4, w: {13'h0003, 13'h1000, 13'h0F0F, 13'h1234}, gap: 2, exp_count: 4,
                exp_run: 52};
    vecs[3] = '{n: 2, w: {13'h0000, 13'h0000, 13'h1FFE, 13'h0000}, gap: 0, exp_count: 2,
                exp_run: 26};

    repeat (3) step();
    check("rst_load_en", 32'(load_en), 0);
    check("rst_load_bit", 32'(load_bit), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(instr_count), 0);
    reset = 1'b0;
    step();
    check("rst_in_ready", 32'(in_ready), 1);

    // Table of complete programs.
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt;
      r0 = run_cnt;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        send_word(vecs[v].w[k], k == int'(vecs[v].n) - 1, 1'b1);
        repeat (vecs[v].gap) step();
      end
      wait_done(d0 + 1, "done_pulse");
      check("run_len", 32'(last_run), vecs[v].exp_run);
      check("instr_count", 32'(instr_count), vecs[v].exp_count);
      check("err_clear", 32'(err), 0);
      check("run_count", 32'(run_cnt - r0), 1);
      step();
      check("done_one_cycle", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check("sb_empty", 32'(bitq.size()), 0);
    end

    // Prefill hold: two words then a stall must not start shifting.
    d0 = done_cnt;
    send_word(13'h0101, 1'b0, 1'b1);
    send_word(13'h1E1E, 1'b0, 1'b1);
    hi = 0;
    repeat (10) begin
      step();
      if (load_en) hi++;
    end
    check("fill_stall", 32'(hi), 0);
    send_word(13'h0077, 1'b0, 1'b1);
    send_word(13'h1800, 1'b0, 1'b1);
    check("prefill_edge_low", 32'(load_en), 0);
    step();
    check("prefill_edge_high", 32'(load_en), 1);
    send_word(13'h0ABC, 1'b1, 1'b1);
    wait_done(d0 + 1, "prefill_done");
    check("prefill_count", 32'(instr_count), 5);

    // Underflow: four words, source goes quiet.
    step();
    for (int k = 0; k < 4; k++) send_word(13'(16'h0321 * (k + 1)), 1'b0, 1'b1);
    t = 0;
    while (!err && t < 200) begin
      step();
      t++;
    end
    check("uf_err", 32'(err), 1);
    check("uf_load_en", 32'(load_en), 0);
    check("uf_run", 32'(last_run), 52);
    check("uf_count", 32'(instr_count), 4);
    send_word(13'h1111, 1'b0, 1'b0);
    check("uf_drain_busy", 32'(busy), 1);
    send_word(13'h0F00, 1'b1, 1'b0);
    check("uf_exit_busy", 32'(busy), 0);
    check("uf_err_sticky", 32'(err), 1);
    d0 = done_cnt;
    send_word(13'h0042, 1'b1, 1'b1);
    check("uf_err_cleared", 32'(err), 0);
    wait_done(d0 + 1, "uf_next_done");
    check("uf_next_count", 32'(instr_count), 1);

    // Reset in the middle of word 2, bit 6.
    step();
    send_word(13'h1357, 1'b0, 1'b1);
    send_word(13'h0246, 1'b0, 1'b1);
    send_word(13'h1ACE, 1'b1, 1'b1);
    t = 0;
    while (run_len != 20 && t < 300) begin
      step();
      t++;
    end
    check("mid_reset_reached", 32'(run_len), 20);
    reset = 1'b1;
    step();
    check("mid_reset_load_en", 32'(load_en), 0);
    check("mid_reset_busy", 32'(busy), 0);
    check("mid_reset_count", 32'(instr_count), 0);
    reset = 1'b0;
    bitq.delete();
    step();
    check("mid_reset_ready", 32'(in_ready), 1);
    d0 = done_cnt;
    send_word(13'h0E0F, 1'b1, 1'b1);
    wait_done(d0 + 1, "post_reset_done");
    check("post_reset_count", 32'(instr_count), 1);
    check("post_reset_run", 32'(last_run), 13);

    // Back-to-back programs.
    step();
    d0 = done_cnt;
    r0 = run_cnt;
    send_word(13'h0F0F, 1'b0, 1'b1);
    send_word(13'h1001, 1'b1, 1'b1);
    send_word(13'h0123, 1'b0, 1'b1);
    send_word(13'h1ABC, 1'b0, 1'b1);
    send_word(13'h0555, 1'b1, 1'b1);
    wait_done(d0 + 2, "b2b_done");
    check("b2b_runs", 32'(run_cnt - r0), 2);
    check("b2b_run", 32'(last_run), 39);
    check("b2b_count", 32'(instr_count), 3);

    // 1001-word program.
    step();
    d0 = done_cnt;
    for (int k = 0; k < 1001; k++) send_word(13'(k * 37 + 5), k == 1000, 1'b1);
`ifdef PROG_LOADER_MAXLEN_EN
    check("maxlen_err", 32'(err), 1);
    check("maxlen_load_en", 32'(load_en), 0);
    bitq.delete();
    step();
    check("maxlen_idle", 32'(busy), 0);
    check("maxlen_no_done", 32'(done_cnt), 32'(d0));
`else
    wait_done(d0 + 1, "long_done");
    check("long_count", 32'(instr_count), 1001);
    check("long_err", 32'(err), 0);
    check("long_sb_empty", 32'(bitq.size()), 0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
